// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch stage,
// acknowledge/data back from memory.
interface fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 12
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage of the 12-bit accumulator CPU: owns PC and IR, fetches over a
// req/ack bus and applies the controller's registered PC-update response.
module fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 12
) (
  input  logic                 clk,
  input  logic                 CLB,
  fetch_unit_if.master         imem,
  input  logic                 IncPC,
  input  logic                 LoadPC,
  input  logic                 SelPC,
  input  logic [PC_W-1:0]      reg_target,
  output logic                 LoadIR,
  output logic [3:0]           Opcode,
  output logic [INSTR_W-5:0]   Operand,
  output logic [PC_W-1:0]      pc,
  output logic                 halted,
  output logic [15:0]          retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [15:0]          retired_q, retired_d;

  // Load beats increment; "neither" holds the PC so the same address is refetched.
  function automatic logic [PC_W-1:0] next_pc(
    input logic [PC_W-1:0] cur,
    input logic [PC_W-1:0] operand_addr,
    input logic [PC_W-1:0] target,
    input logic            inc,
    input logic            load,
    input logic            sel
  );
    logic [PC_W-1:0] res;
    res = cur;
    if (load) begin
      res = sel ? target : operand_addr;
    end else if (inc) begin
      res = cur + {{(PC_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_UPDATE;
      S_UPDATE: begin
        retired_d = retired_q + 16'd1;
        if (ir_q[INSTR_W-1:INSTR_W-4] == 4'hF) begin
          state_d = S_HALT;
        end else begin
          pc_d    = next_pc(pc_q, ir_q[PC_W-1:0], reg_target, IncPC, LoadPC, SelPC);
          state_d = S_FETCH;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Every output comes from registers or the state decode, never from imem_* inputs.
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = (state_q == S_FETCH) ? pc_q : '0;
  assign LoadIR         = (state_q == S_DECODE);
  assign halted         = (state_q == S_HALT);
  assign Opcode         = ir_q[INSTR_W-1:INSTR_W-4];
  assign Operand        = ir_q[INSTR_W-5:0];
  assign pc             = pc_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of instructions with hand-computed
// PC results, plus sequences for reset, halt and reset during a fetch wait.
module tb_fetch_unit;

  logic        clk;
  logic        CLB;
  logic        IncPC, LoadPC, SelPC;
  logic [7:0]  reg_target;
  logic        LoadIR;
  logic [3:0]  Opcode;
  logic [7:0]  Operand;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  fetch_unit_if #(.PC_W(8), .INSTR_W(12)) bus ();

  fetch_unit #(.PC_W(8), .INSTR_W(12)) dut (
    .clk        (clk),
    .CLB        (CLB),
    .imem       (bus.master),
    .IncPC      (IncPC),
    .LoadPC     (LoadPC),
    .SelPC      (SelPC),
    .reg_target (reg_target),
    .LoadIR     (LoadIR),
    .Opcode     (Opcode),
    .Operand    (Operand),
    .pc         (pc),
    .halted     (halted),
    .retired    (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [11:0] instr;
    int          wt;
    logic        inc;
    logic        ld;
    logic        sel;
    logic [7:0]  tgt;
    logic        stray;
    logic [7:0]  exp_pc;
  } vec_t;

  vec_t vecs [12];
  logic [7:0]  exp_addr;
  logic [11:0] last_ir;
  logic [15:0] exp_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts sampled in a FETCH cycle; ends sampled in the next FETCH (or HALT).
  task automatic run_instr(input vec_t v);
    for (int i = 0; i < v.wt; i++) begin
      bus.imem_ack = 1'b0;
      tick();
      chk("wait_req", bus.imem_req, 1'b1);
      chk("wait_addr", bus.imem_addr, exp_addr);
      chk("wait_ir", {Opcode, Operand}, last_ir);
      chk("wait_loadir", LoadIR, 1'b0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.instr;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 12'h000;
    chk("dec_loadir", LoadIR, 1'b1);
    chk("dec_ir", {Opcode, Operand}, v.instr);
    chk("dec_req", bus.imem_req, 1'b0);
    IncPC      = v.inc;
    LoadPC     = v.ld;
    SelPC      = v.sel;
    reg_target = v.tgt;
    if (v.stray) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 12'hEEE;
    end
    tick();
    bus.imem_ack = 1'b0;
    chk("upd_loadir", LoadIR, 1'b0);
    chk("upd_ir", {Opcode, Operand}, v.instr);
    chk("upd_pc_hold", pc, exp_addr);
    tick();
    IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0; reg_target = 8'h00;
    exp_ret++;
    chk("pc_next", pc, v.exp_pc);
    chk("retired", retired, exp_ret);
    if (v.instr[11:8] == 4'hF) begin
      chk("halt_flag", halted, 1'b1);
      chk("halt_req", bus.imem_req, 1'b0);
    end else begin
      chk("refetch_req", bus.imem_req, 1'b1);
      chk("refetch_addr", bus.imem_addr, v.exp_pc);
      chk("run_halted", halted, 1'b0);
    end
    last_ir  = v.instr;
    exp_addr = v.exp_pc;
  endtask

  initial begin
    //          instr    wt inc  ld   sel  tgt    stray exp_pc
    vecs[0]  = '{12'h105, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01};
    vecs[1]  = '{12'h203, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h02};
    vecs[2]  = '{12'h101, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h03};
    vecs[3]  = '{12'h340, 4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04};
    vecs[4]  = '{12'h740, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h40};
    vecs[5]  = '{12'h700, 0, 1'b0, 1'b1, 1'b1, 8'h9A, 1'b0, 8'h9A};
    vecs[6]  = '{12'h755, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h9A};
    vecs[7]  = '{12'h755, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h9A};
    vecs[8]  = '{12'h7FF, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF};
    vecs[9]  = '{12'h100, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{12'h710, 2, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 8'h10};
    vecs[11] = '{12'hF00, 0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h10};

    CLB = 1'b0;
    IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0; reg_target = 8'h00;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 12'hF00;
    exp_addr = 8'h00; last_ir = 12'h000; exp_ret = 16'h0000;

    // Reset held with a toggling ack: nothing may move.
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = ~bus.imem_ack;
      tick();
      chk("rst_req", bus.imem_req, 1'b0);
    end
    chk("rst_addr", bus.imem_addr, 8'h00);
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", {Opcode, Operand}, 12'h000);
    chk("rst_loadir", LoadIR, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 16'h0000);
    bus.imem_ack = 1'b0;
    CLB = 1'b1;
    #1;
    chk("idle_req", bus.imem_req, 1'b0);
    tick();
    chk("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, 8'h00);
    tick();
    chk("first_req2", bus.imem_req, 1'b1);
    chk("first_addr2", bus.imem_addr, 8'h00);

    for (int n = 0; n < 12; n++) begin
      run_instr(vecs[n]);
    end

    // Halted: frozen regardless of memory activity.
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack   = (i % 2) == 0;
      bus.imem_rdata = 12'h1AB;
      IncPC = 1'b1;
      tick();
      chk("halt_pc", pc, 8'h10);
      chk("halt_hold", {halted, bus.imem_req, LoadIR}, 3'b100);
    end
    chk("halt_ir", {Opcode, Operand}, 12'hF00);
    chk("halt_retired", retired, 16'd12);
    IncPC = 1'b0;
    bus.imem_ack = 1'b0;

    // Fresh start, one instruction, then reset inside a waiting fetch.
    CLB = 1'b0;
    #1;
    chk("rst2_halted", halted, 1'b0);
    CLB = 1'b1;
    tick();
    exp_addr = 8'h00; last_ir = 12'h000; exp_ret = 16'h0000;
    chk("rst2_req", bus.imem_req, 1'b1);
    run_instr('{12'h123, 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01});
    tick();
    tick();
    chk("midf_req", bus.imem_req, 1'b1);
    chk("midf_addr", bus.imem_addr, 8'h01);
    #2;
    CLB = 1'b0;
    #1;
    chk("async_req", bus.imem_req, 1'b0);
    chk("async_pc", pc, 8'h00);
    chk("async_ir", {Opcode, Operand}, 12'h000);
    chk("async_retired", retired, 16'h0000);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 12'h456;
    tick();
    chk("late_ack_ir", {Opcode, Operand}, 12'h000);
    CLB = 1'b1;
    tick();
    chk("late_ack_req", bus.imem_req, 1'b1);
    chk("late_ack_ir2", {Opcode, Operand}, 12'h000);
    chk("late_ack_loadir", LoadIR, 1'b0);
    bus.imem_ack = 1'b0;
    tick();
    chk("late_ack_wait", {bus.imem_req, LoadIR}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
